univ_shift_reg: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with true and complemented outputs.
- Adds asynchronous reset, a clock enable and eight operating modes: hold, parallel load, logical shifts, rotates, arithmetic shift and synchronous clear.
- Used as the general-purpose shifter/accumulator register in the lab datapath.
- Storage is built from per-bit flip-flop cells.

---
 rtl/usr_pkg.sv | 15 +
 rtl/dff_ar.sv | 31 +++
 rtl/univ_shift_reg.sv | 84 ++++++++
 tb/tb_univ_shift_reg.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared mode encoding for the universal shift register.
package usr_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'd6;
  localparam logic [MODE_W-1:0] MODE_CLR  = 3'd7;

endpackage

// File: rtl/dff_ar.sv
// One storage bit: async active-high reset to a per-bit value, clock enable,
// and a separately registered complement so qbar never lags or glitches vs q.
module dff_ar #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q,
  output logic qbar
);

  logic q_q;
  logic qbar_q;

  // Bit storage and its complement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= RST_VAL;
      qbar_q <= ~RST_VAL;
    end else if (en) begin
      q_q    <= d;
      qbar_q <= ~d;
    end
  end

  assign q    = q_q;
  assign qbar = qbar_q;

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: hold/load/shift/rotate/arith-shift/clear,
// built from per-bit dff_ar cells with the next-state mux kept here.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin_lsb,
  input  logic              sin_msb,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qbar,
  output logic              sout_msb,
  output logic              sout_lsb,
  output logic              zero
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] qbar_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] shl_s, shr_s, rol_s, ror_s, asr_s;

  // Per-bit neighbour selection; end bits are elaborated separately so that
  // WIDTH = 1 collapses cleanly (rotates and ASR become identity).
  for (genvar i = 0; i < WIDTH; i++) begin : g_nbr
    if (i == 0) begin : g_lo
      assign shl_s[i] = sin_lsb;
      assign rol_s[i] = q_q[WIDTH-1];
    end else begin : g_lo_n
      assign shl_s[i] = q_q[i-1];
      assign rol_s[i] = q_q[i-1];
    end
    if (i == WIDTH-1) begin : g_hi
      assign shr_s[i] = sin_msb;
      assign ror_s[i] = q_q[0];
      assign asr_s[i] = q_q[WIDTH-1];
    end else begin : g_hi_n
      assign shr_s[i] = q_q[i+1];
      assign ror_s[i] = q_q[i+1];
      assign asr_s[i] = q_q[i+1];
    end
  end

  // Next-state mux
  always_comb begin
    q_d = q_q;
    case (mode)
      MODE_HOLD: q_d = q_q;
      MODE_LOAD: q_d = d;
      MODE_SHL:  q_d = shl_s;
      MODE_SHR:  q_d = shr_s;
      MODE_ROL:  q_d = rol_s;
      MODE_ROR:  q_d = ror_s;
      MODE_ASR:  q_d = asr_s;
      MODE_CLR:  q_d = {WIDTH{1'b0}};
      default:   q_d = q_q;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_ar #(
      .RST_VAL (RESET_VALUE[i])
    ) u_ff (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .d    (q_d[i]),
      .q    (q_q[i]),
      .qbar (qbar_q[i])
    );
  end

  assign q        = q_q;
  assign qbar     = qbar_q;
  assign sout_msb = q_q[WIDTH-1];
  assign sout_lsb = q_q[0];
  assign zero     = (q_q == {WIDTH{1'b0}});

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed and randomized checks of univ_shift_reg at WIDTH=8 and WIDTH=1.
module tb_univ_shift_reg;
  import usr_pkg::*;

  localparam logic [7:0] RV8 = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset8 = 1'b0, en8 = 1'b0, sl8 = 1'b0, sm8 = 1'b0;
  logic [MODE_W-1:0] mode8 = MODE_HOLD;
  logic [7:0]        d8 = 8'h00, q8, qb8;
  logic              so_msb8, so_lsb8, zero8;

  logic              reset1 = 1'b1, en1 = 1'b0, sl1 = 1'b0, sm1 = 1'b0;
  logic [MODE_W-1:0] mode1 = MODE_HOLD;
  logic [0:0]        d1 = 1'b0, q1, qb1;
  logic              so_msb1, so_lsb1, zero1;

  int n_checks = 0;
  int n_fail   = 0;

  univ_shift_reg #(.WIDTH(8), .RESET_VALUE(RV8)) u_dut8 (
    .clk(clk), .reset(reset8), .en(en8), .mode(mode8), .d(d8),
    .sin_lsb(sl8), .sin_msb(sm8), .q(q8), .qbar(qb8),
    .sout_msb(so_msb8), .sout_lsb(so_lsb8), .zero(zero8)
  );

  univ_shift_reg #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut1 (
    .clk(clk), .reset(reset1), .en(en1), .mode(mode1), .d(d1),
    .sin_lsb(sl1), .sin_msb(sm1), .q(q1), .qbar(qb1),
    .sout_msb(so_msb1), .sout_lsb(so_lsb1), .zero(zero1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the mode rules written as arithmetic on an unsigned value of width w.
  function automatic logic [63:0] ref_next(input int w, input logic [63:0] qv, input int m,
                                           input logic [63:0] dv, input logic sl, input logic sm);
    logic [63:0] mask, msb, lsb, slv, smv;
    mask = (w == 64) ? ~64'd0 : ((64'd1 << w) - 64'd1);
    msb  = (qv >> (w - 1)) & 64'd1;
    lsb  = qv & 64'd1;
    slv  = {63'd0, sl};
    smv  = {63'd0, sm};
    case (m)
      0:       return qv;
      1:       return dv & mask;
      2:       return ((qv << 1) | slv) & mask;
      3:       return (qv >> 1) | (smv << (w - 1));
      4:       return ((qv << 1) | msb) & mask;
      5:       return (qv >> 1) | (lsb << (w - 1));
      6:       return (qv >> 1) | (msb << (w - 1));
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk8(input string tag, input logic [7:0] e);
    chk({tag, ".q"},    {56'd0, q8},  {56'd0, e});
    chk({tag, ".qbar"}, {56'd0, qb8}, {56'd0, ~e});
    chk({tag, ".smsb"}, {63'd0, so_msb8}, {63'd0, e[7]});
    chk({tag, ".slsb"}, {63'd0, so_lsb8}, {63'd0, e[0]});
    chk({tag, ".zero"}, {63'd0, zero8}, {63'd0, (e == 8'h00)});
  endtask

  task automatic chk1(input string tag, input logic e);
    chk({tag, ".q"},    {63'd0, q1[0]},  {63'd0, e});
    chk({tag, ".qbar"}, {63'd0, qb1[0]}, {63'd0, ~e});
    chk({tag, ".smsb"}, {63'd0, so_msb1}, {63'd0, e});
    chk({tag, ".slsb"}, {63'd0, so_lsb1}, {63'd0, e});
    chk({tag, ".zero"}, {63'd0, zero1}, {63'd0, ~e});
  endtask

  logic [63:0] m8, m1;
  int          r_mode;

  initial begin
    // Reset asserted between edges takes effect immediately
    #2 reset8 = 1'b1;
    #1 chk8("rst_async", 8'hA5);
    en8 = 1'b1; mode8 = MODE_LOAD; d8 = 8'h00;
    step(); chk8("rst_clk_ignored_a", 8'hA5);
    step(); chk8("rst_clk_ignored_b", 8'hA5);
    reset8 = 1'b0; reset1 = 1'b0; mode8 = MODE_HOLD;
    chk1("w1_rst", 1'b0);
    step(); chk8("hold_after_rst", 8'hA5);

    mode8 = MODE_LOAD; d8 = 8'h81;
    step(); chk8("load81", 8'h81);
    chk("sout_msb_pre_shl", {63'd0, so_msb8}, 64'd1);
    mode8 = MODE_SHL; sl8 = 1'b1;
    step(); chk8("shl", 8'h03);
    mode8 = MODE_SHR; sm8 = 1'b0;
    step(); chk8("shr", 8'h01);

    mode8 = MODE_LOAD; d8 = 8'h81; step();
    mode8 = MODE_ROL; step(); chk8("rol", 8'h03);
    mode8 = MODE_LOAD; d8 = 8'h81; step();
    mode8 = MODE_ROR; step(); chk8("ror", 8'hC0);
    mode8 = MODE_LOAD; d8 = 8'h90; step();
    mode8 = MODE_ASR; step(); chk8("asr1", 8'hC8);
    step(); chk8("asr2", 8'hE4);

    en8 = 1'b0; mode8 = MODE_CLR;
    step(); step(); step(); chk8("en0_clr", 8'hE4);
    en8 = 1'b0; mode8 = MODE_LOAD; d8 = 8'h11;
    step(); chk8("en0_load", 8'hE4);
    en8 = 1'b1; mode8 = MODE_CLR;
    step(); chk8("clr", 8'h00);

    mode8 = MODE_LOAD; d8 = 8'h3C;
    step(); chk8("load3c", 8'h3C);
    #2 reset8 = 1'b1;
    #1 chk8("rst_mid", 8'hA5);
    #1 reset8 = 1'b0;
    mode8 = MODE_SHL; sl8 = 1'b0;
    step(); chk8("shl_after_rst", 8'h4A);

    // Reset coincident with a clock edge: reset must win over LOAD
    mode8 = MODE_LOAD; d8 = 8'h00;
    @(posedge clk); reset8 = 1'b1;
    #1 chk8("rst_at_edge", 8'hA5);
    reset8 = 1'b0;

    // WIDTH = 1 boundary
    en1 = 1'b1; mode1 = MODE_LOAD; d1 = 1'b1;
    step(); chk1("w1_load", 1'b1);
    mode1 = MODE_ROL; step(); chk1("w1_rol", 1'b1);
    mode1 = MODE_ASR; step(); chk1("w1_asr", 1'b1);
    mode1 = MODE_ROR; step(); chk1("w1_ror", 1'b1);
    mode1 = MODE_SHR; sm1 = 1'b0; step(); chk1("w1_shr", 1'b0);
    mode1 = MODE_SHL; sl1 = 1'b1; step(); chk1("w1_shl", 1'b1);

    // Randomized phase against the arithmetic reference
    m8 = {56'd0, q8};
    m1 = {63'd0, q1[0]};
    for (int i = 0; i < 300; i++) begin
      en8 = ($urandom_range(0, 4) != 0); r_mode = $urandom_range(0, 7);
      mode8 = r_mode[MODE_W-1:0]; d8 = 8'($urandom);
      sl8 = 1'($urandom); sm8 = 1'($urandom);
      en1 = ($urandom_range(0, 4) != 0); r_mode = $urandom_range(0, 7);
      mode1 = r_mode[MODE_W-1:0]; d1 = 1'($urandom);
      sl1 = 1'($urandom); sm1 = 1'($urandom);
      step();
      if (en8) m8 = ref_next(8, m8, int'(mode8), {56'd0, d8}, sl8, sm8);
      if (en1) m1 = ref_next(1, m1, int'(mode1), {63'd0, d1}, sl1, sm1);
      chk8("rnd8", m8[7:0]);
      chk1("rnd1", m1[0]);
      if ($urandom_range(0, 19) == 0) begin
        #2 reset8 = 1'b1;
        #1 m8 = {56'd0, RV8};
        chk8("rnd8_rst", m8[7:0]);
        #1 reset8 = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
